// File: rtl/flp_pkg.sv
// Shared encodings for the host-side floppy bus controller: command opcodes,
// FSM states and 34-pin bus polarity constants.
package flp_pkg;

   localparam logic [1:0] OP_SEEK      = 2'd0;
   localparam logic [1:0] OP_RECAL     = 2'd1;
   localparam logic [1:0] OP_MOTOR_ON  = 2'd2;
   localparam logic [1:0] OP_MOTOR_OFF = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DIR_SETUP,
      ST_STEP_LOW,
      ST_STEP_HIGH,
      ST_SETTLE,
      ST_SPINUP,
      ST_FINISH
   } flp_state_t;

   localparam logic ASSERT_N   = 1'b0;
   localparam logic DEASSERT_N = 1'b1;
   localparam logic DIR_IN     = 1'b0;
   localparam logic DIR_OUT    = 1'b1;

endpackage

// File: rtl/flp_in_sync.sv
// Two-flop synchronizer for an active-low drive status line, with a
// falling-edge (assertion) strobe derived from the synchronized value.
module flp_in_sync
   import flp_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic fall
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   // Idle bus lines float high, so all stages reset to the deasserted level.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta_q <= DEASSERT_N;
         sync_q <= DEASSERT_N;
         prev_q <= DEASSERT_N;
      end else begin
         meta_q <= async_in;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign sync_out = sync_q;
   assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/flp_host_ctrl.sv
// Host-side floppy controller: accepts SEEK/RECAL/MOTOR commands and drives
// timed active-low step pulses, direction, select and motor lines.
//
// state        | meaning
// -------------+----------------------------------------------------------
// ST_IDLE      | cmd_ready high, waiting for a command
// ST_DIR_SETUP | dir_sel settling before the first step
// ST_STEP_LOW  | step held low
// ST_STEP_HIGH | step high for the rest of the step period
// ST_SETTLE    | head settle after the last step
// ST_SPINUP    | motor spin-up wait
// ST_FINISH    | done (and err) asserted for one cycle
module flp_host_ctrl
   import flp_pkg::*;
#(
   parameter int DRIVE_NUM     = 1,
   parameter int STEP_LOW_CYC  = 6000,
   parameter int STEP_RATE_CYC = 30000,
   parameter int DIR_SETUP_CYC = 10,
   parameter int SETTLE_CYC    = 150000,
   parameter int SPINUP_CYC    = 5000000,
   parameter int MAX_TRACK     = 79,
   parameter int RECAL_MAX     = 85
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [6:0] cmd_track,
   input  logic       hi_speed,
   output logic       done,
   output logic       err,
   output logic [6:0] cur_track,
   output logic       track_valid,
   output logic       index_pulse,
   output logic       wr_prot,
   output logic [3:0] drive_sel,
   output logic       motor_on,
   output logic       dens_sel,
   output logic       dir_sel,
   output logic       step,
   input  logic       index,
   input  logic       track_0,
   input  logic       wr_protect
);

   localparam logic [23:0] T_DIR    = 24'(DIR_SETUP_CYC - 1);
   localparam logic [23:0] T_LOW    = 24'(STEP_LOW_CYC - 1);
   localparam logic [23:0] T_HIGH   = 24'(STEP_RATE_CYC - STEP_LOW_CYC - 1);
   localparam logic [23:0] T_SETTLE = 24'(SETTLE_CYC - 1);
   localparam logic [23:0] T_SPINUP = 24'(SPINUP_CYC - 1);
   localparam logic [6:0]  MAX_T    = 7'(MAX_TRACK);
   localparam logic [7:0]  RECAL_LIM = 8'(RECAL_MAX);

   flp_state_t  state;
   logic [23:0] timer;
   logic [1:0]  op_q;
   logic [6:0]  target_q;
   logic [7:0]  step_cnt;
   logic        motor_en;
   logic        sel;

   logic idx_sync, idx_fall;
   logic t0_sync, t0_fall;
   logic wp_sync, wp_fall;
   logic unused_sync_bits;

   flp_in_sync u_sync_index (
      .clk      (clk),
      .rst      (rst),
      .async_in (index),
      .sync_out (idx_sync),
      .fall     (idx_fall)
   );

   flp_in_sync u_sync_track_0 (
      .clk      (clk),
      .rst      (rst),
      .async_in (track_0),
      .sync_out (t0_sync),
      .fall     (t0_fall)
   );

   flp_in_sync u_sync_wr_protect (
      .clk      (clk),
      .rst      (rst),
      .async_in (wr_protect),
      .sync_out (wp_sync),
      .fall     (wp_fall)
   );

   assign unused_sync_bits = idx_sync ^ t0_fall ^ wp_fall;

   assign sel       = (state != ST_IDLE) || motor_en;
   assign cmd_ready = (state == ST_IDLE);
   assign motor_on  = motor_en ? ASSERT_N : DEASSERT_N;
   assign dens_sel  = hi_speed;

   always_comb begin
      drive_sel = '1;
      if (sel) drive_sel[DRIVE_NUM[1:0]] = ASSERT_N;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         timer       <= '0;
         op_q        <= OP_SEEK;
         target_q    <= '0;
         step_cnt    <= '0;
         motor_en    <= 1'b0;
         cur_track   <= '0;
         track_valid <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         index_pulse <= 1'b0;
         wr_prot     <= 1'b0;
         dir_sel     <= DIR_OUT;
         step        <= DEASSERT_N;
      end else begin
         done        <= 1'b0;
         err         <= 1'b0;
         index_pulse <= sel && idx_fall;
         wr_prot     <= sel && (wp_sync == ASSERT_N);

         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  op_q     <= cmd_op;
                  target_q <= cmd_track;
                  step_cnt <= '0;
                  case (cmd_op)
                     OP_SEEK: begin
                        if (!track_valid || cmd_track > MAX_T) begin
                           state <= ST_FINISH;
                           done  <= 1'b1;
                           err   <= 1'b1;
                        end else if (cmd_track == cur_track) begin
                           state <= ST_FINISH;
                           done  <= 1'b1;
                        end else begin
                           dir_sel <= (cmd_track > cur_track) ? DIR_IN : DIR_OUT;
                           timer   <= T_DIR;
                           state   <= ST_DIR_SETUP;
                        end
                     end
                     OP_RECAL: begin
                        dir_sel <= DIR_OUT;
                        timer   <= T_DIR;
                        state   <= ST_DIR_SETUP;
                     end
                     OP_MOTOR_ON: begin
                        motor_en <= 1'b1;
                        timer    <= T_SPINUP;
                        state    <= ST_SPINUP;
                     end
                     default: begin
                        motor_en <= 1'b0;
                        state    <= ST_FINISH;
                        done     <= 1'b1;
                     end
                  endcase
               end
            end

            ST_DIR_SETUP: begin
               if (timer == '0) begin
                  // A RECAL already sitting on track 0 completes without stepping.
                  if (op_q == OP_RECAL && t0_sync == ASSERT_N) begin
                     cur_track   <= '0;
                     track_valid <= 1'b1;
                     state       <= ST_FINISH;
                     done        <= 1'b1;
                  end else begin
                     step  <= ASSERT_N;
                     timer <= T_LOW;
                     state <= ST_STEP_LOW;
                  end
               end else begin
                  timer <= timer - 24'd1;
               end
            end

            ST_STEP_LOW: begin
               if (timer == '0) begin
                  step     <= DEASSERT_N;
                  timer    <= T_HIGH;
                  state    <= ST_STEP_HIGH;
                  step_cnt <= step_cnt + 8'd1;
                  if (op_q == OP_SEEK)
                     cur_track <= (dir_sel == DIR_IN) ? cur_track + 7'd1 : cur_track - 7'd1;
               end else begin
                  timer <= timer - 24'd1;
               end
            end

            ST_STEP_HIGH: begin
               if (timer == '0) begin
                  if (op_q == OP_RECAL) begin
                     if (t0_sync == ASSERT_N) begin
                        cur_track   <= '0;
                        track_valid <= 1'b1;
                        timer       <= T_SETTLE;
                        state       <= ST_SETTLE;
                     end else if (step_cnt == RECAL_LIM) begin
                        track_valid <= 1'b0;
                        state       <= ST_FINISH;
                        done        <= 1'b1;
                        err         <= 1'b1;
                     end else begin
                        step  <= ASSERT_N;
                        timer <= T_LOW;
                        state <= ST_STEP_LOW;
                     end
                  end else if (cur_track == target_q) begin
                     timer <= T_SETTLE;
                     state <= ST_SETTLE;
                  end else begin
                     step  <= ASSERT_N;
                     timer <= T_LOW;
                     state <= ST_STEP_LOW;
                  end
               end else begin
                  timer <= timer - 24'd1;
               end
            end

            ST_SETTLE, ST_SPINUP: begin
               if (timer == '0) begin
                  state <= ST_FINISH;
                  done  <= 1'b1;
               end else begin
                  timer <= timer - 24'd1;
               end
            end

            ST_FINISH: state <= ST_IDLE;

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/flp_host_ctrl.md
Name: flp_host_ctrl

Overview:
- Host-side floppy interface controller. It drives the 34-pin bus lines that our drive-side controller circuit consumes: drive select, motor on, density select, direction, and step.
- It samples the drive's index, track 00 and write-protect lines.
- Host logic (MCU bridge or FPGA core) issues SEEK / RECAL / MOTOR_ON / MOTOR_OFF commands over a valid/ready handshake. The block generates correctly timed active-low step pulses and tracks head position.
- It runs on the same 10 MHz system clock as the drive side.

Parameters:
- DRIVE_NUM, 1, bus drive-select index asserted by this host (0-3)
- STEP_LOW_CYC, 6000, step low width in clocks (0.6 ms; exceeds drive-side debounce)
- STEP_RATE_CYC, 30000, full step period, falling edge to falling edge (3 ms); must be > STEP_LOW_CYC
- DIR_SETUP_CYC, 10, dir_sel stable time before the first step falling edge
- SETTLE_CYC, 150000, head settle after the last step (15 ms)
- SPINUP_CYC, 5000000, motor spin-up wait (500 ms)
- MAX_TRACK, 79, highest legal track
- RECAL_MAX, 85, step limit for RECAL before error

Ports:
- clk  in  1  system clock, 10 MHz
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_op  in  2  0=SEEK 1=RECAL 2=MOTOR_ON 3=MOTOR_OFF
- cmd_track  in  7  SEEK target track
- hi_speed  in  1  1 = 360 rpm / HD; drives dens_sel directly
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done
- cur_track  out  7  current head track
- track_valid  out  1  cur_track known (set by a successful RECAL)
- index_pulse  out  1  one-cycle pulse per index falling edge, selected only
- wr_prot  out  1  synced write-protect, selected only
- drive_sel  out  4  active-low bus drive selects
- motor_on  out  1  active-low
- dens_sel  out  1  = hi_speed
- dir_sel  out  1  active-low; low = toward higher tracks
- step  out  1  active-low step pulse
- index  in  1  active-low, asynchronous
- track_0  in  1  active-low, asynchronous
- wr_protect  in  1  active-low, asynchronous

Behaviour:
- Reset values:
  - drive_sel=4'b1111; motor_on=1, dir_sel=1, step=1.
  - cur_track=0, track_valid=0, done=0, err=0, index_pulse=0, wr_prot=0.
  - Motor-enable register cleared; FSM in IDLE; cmd_ready=1 from the first cycle after reset.
- Reset mid-operation: same values on the next edge. A step pulse in flight is cut short (step=1 immediately).
- Bus inputs pass through 2-flop synchronizers; index_pulse adds 3 cycles of latency from the bus edge.
- Selection:
  - drive_sel[DRIVE_NUM]=0 while state!=IDLE or the motor-enable register is set; other bits always 1.
  - index_pulse and wr_prot are forced 0 when not selected.
- Handshake:
  - Accept on cmd_valid&&cmd_ready; cmd_op and cmd_track are captured then.
  - cmd_ready drops the following cycle.
  - done pulses once per accepted command; cmd_ready returns the cycle after done.
- FSM states: IDLE, DIR_SETUP, STEP_LOW, STEP_HIGH, SETTLE, SPINUP, FINISH. FINISH asserts done for one cycle, then the FSM returns to IDLE.
- Timer: one 24-bit down-counter; all cycle parameters must be < 2^24.
- MOTOR_ON: set motor_on=0, enter SPINUP for SPINUP_CYC cycles, then FINISH, err=0.
- MOTOR_OFF: set motor_on=1, then FINISH the next cycle. A MOTOR_ON issued while the motor is already on still waits the full spin-up.
- SEEK, error cases: if track_valid=0 or cmd_track>MAX_TRACK, go to FINISH with err=1 and no bus activity.
- SEEK, at target: if cmd_track==cur_track, go to FINISH with err=0 and no steps.
- SEEK, stepping:
  - Set dir_sel (0 if target>cur_track), then DIR_SETUP for DIR_SETUP_CYC cycles.
  - STEP_LOW holds step=0 for STEP_LOW_CYC cycles.
  - STEP_HIGH holds step=1 for STEP_RATE_CYC-STEP_LOW_CYC cycles.
  - cur_track is updated by ±1 on the step rising edge.
  - Repeat until cur_track==target, then SETTLE for SETTLE_CYC cycles, then FINISH with err=0.
- RECAL, start:
  - dir_sel=1, then DIR_SETUP.
  - At the end of DIR_SETUP, if synced track_0==0: cur_track=0, track_valid=1, FINISH (no steps, no settle).
- RECAL, stepping:
  - Step outward, checking track_0 at the end of each STEP_HIGH.
  - When track_0 is seen: cur_track=0, track_valid=1, SETTLE, then FINISH with err=0.
  - After RECAL_MAX steps without track_0: track_valid=0, FINISH with err=1.
- dir_sel holds its value between commands. step never goes low outside STEP_LOW.
- hi_speed is combinational to dens_sel with no state effect.

Decomposition:
- Shared package flp_pkg holds:
  - cmd_op encoding constants;
  - FSM state enum;
  - bus polarity constants: ASSERT_N=0, DEASSERT_N=1, DIR_IN=0, DIR_OUT=1.
- One sub-module, flp_in_sync: 2-flop synchronizer plus falling-edge detect, instantiated three times (index, track_0, wr_protect).

Test Plan:
All scenarios use overrides STEP_LOW_CYC=6, STEP_RATE_CYC=20, DIR_SETUP_CYC=2, SETTLE_CYC=10, SPINUP_CYC=50, RECAL_MAX=85.
1. Reset: all bus outputs 1, drive_sel=1111, cmd_ready=1, track_valid=0.
2. SEEK 5 before any RECAL -> done with err=1 one FSM pass later; step never goes low.
3. RECAL with the drive model asserting track_0 after 3 steps -> exactly 3 step pulses, each low 6 cycles with falling edges 20 cycles apart; dir_sel=1 throughout; done, err=0, cur_track=0, track_valid=1.
4. SEEK 4 then SEEK 1 -> 4 pulses with dir_sel=0 and cur_track 1,2,3,4 at each rising edge; then 3 pulses with dir_sel=1 ending at 1; SEEK 1 again -> done with no pulses; SEEK 80 -> err=1.
5. RECAL with track_0 held high -> exactly 85 pulses, then err=1 and track_valid=0.
6. MOTOR_ON -> motor_on=0 and drive_sel[1]=0 immediately; done after 50 cycles; index low pulse yields one index_pulse 3 cycles later; MOTOR_OFF -> motor_on=1, drive_sel=1111 after done; index activity then yields no index_pulse; rst asserted mid-step forces step=1 on the next edge.
